multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Next-generation MIPS-subset controller for the multicycle datapath. Replaces per-instruction combinational decode with a registered FSM.
- Sequences FETCH/DECODE/EXEC/MEM/WB and handshakes with a single shared memory through mem_ready.
- Adds a memory-wait timeout with a sticky fault, one-cycle illegal-instruction reporting, and a parametrised ALUOp width.
- Sits between the instruction register (opCode/funct) and the datapath muxes, register file, ALU and memory.

Parameters:
- ALUOP_W, 3, ALUOp width; minimum 3; upper bits are always 0.
- WAIT_LIMIT, 15, maximum consecutive mem_ready-low cycles tolerated in a memory state.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- opCode  in  6  instruction opcode from the IR; valid from DECODE onward.
- funct  in  6  R-type function field from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  instruction register load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemReadEn  out  1  memory read strobe.
- MemWriteEn  out  1  memory write strobe.
- RegDst  out  1  destination register select: 1 = rd, 0 = rt.
- MemtoReg  out  1  write-back data select: 1 = MDR, 0 = ALUOut.
- RegWriteEn  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 0 = rt, 1 = 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- PCSrc  out  1  PC source: 0 = ALU result, 1 = ALUOut (branch target).
- ALUOp  out  ALUOP_W  ALU operation: add 0, sub 1, and 2, or 3, slt 4.
- illegal  out  1  one-cycle pulse on an unsupported opcode or R-type funct.
- fault  out  1  sticky memory-timeout flag.
- state  out  3  current FSM state, for debug.

Behaviour:
- State encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, FAULT 7.
- Reset (rst = 0, asynchronous): state = FETCH, wait counter = 0, fault = 0. While rst is low, all outputs are forced to 0, including MemReadEn.
- Any output not listed for a state below is 0.
- FETCH:
  - MemReadEn = 1, IorD = 0.
  - Hold until mem_ready = 1.
  - In the mem_ready cycle: IRWrite = 1, PCWrite = 1, ALUSrcA = 0, ALUSrcB = 1, ALUOp = add, PCSrc = 0. Next state DECODE.
- DECODE:
  - Latch opCode and funct into internal registers; the IR may change afterwards.
  - ALUSrcA = 0, ALUSrcB = 3, ALUOp = add (precomputes the branch target).
  - Supported opcodes (0x00, 0x08, 0x23, 0x2b, 0x04) go to EXEC.
  - Any other opcode, or an R-type with funct not in {0x20, 0x22, 0x24, 0x25, 0x2a}: illegal = 1 for this cycle, next state FETCH, no writes.
- EXEC:
  - R-type: ALUSrcA = 1, ALUSrcB = 0, ALUOp from funct; next state WB.
  - addi: ALUSrcA = 1, ALUSrcB = 2, add; next state WB.
  - lw / sw: ALUSrcA = 1, ALUSrcB = 2, add; next state MEM.
  - beq: ALUSrcA = 1, ALUSrcB = 0, sub, PCSrc = 1, PCWrite = zero; next state FETCH.
- MEM:
  - IorD = 1. lw asserts MemReadEn; sw asserts MemWriteEn.
  - The strobe is held until and including the mem_ready cycle.
  - On mem_ready: lw goes to WB, sw goes to FETCH.
- WB:
  - R-type: RegDst = 1, RegWriteEn = 1.
  - addi: RegDst = 0, RegWriteEn = 1.
  - lw: RegDst = 0, MemtoReg = 1, RegWriteEn = 1.
  - Next state FETCH.
- Instruction latency with zero-wait memory:
  - beq: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- Wait counter ($clog2(WAIT_LIMIT+1) bits):
  - Increments each FETCH/MEM cycle with mem_ready = 0.
  - Clears on mem_ready = 1 and on every state change.
  - When the counter equals WAIT_LIMIT and mem_ready is still 0, next state is FAULT.
- FAULT: fault = 1, all strobes and enables 0. The FSM stays in FAULT until rst is asserted.
- Reset mid-access: strobes drop immediately (asynchronous); the FSM restarts at FETCH.

Optional Feature:
- Macro EXT_BRANCH_EN.
- Defined:
  - bne (0x05): EXEC as beq, but PCWrite = ~zero.
  - j (0x02): DECODE goes straight to FETCH with PCWrite = 1 and PCSrc = 1; the datapath provides the jump target on ALUOut.
- Undefined: 0x05 and 0x02 are illegal (pulse illegal, return to FETCH).

Test Plan:
- add (op 0x00, funct 0x20), mem_ready always 1 -> states 0,1,2,4,0; RegWriteEn = 1 and RegDst = 1 only in cycle 4; ALUOp = 0 in EXEC.
- lw (0x23) with mem_ready low for 3 MEM cycles -> MemReadEn and IorD = 1 held for 4 cycles; WB has MemtoReg = 1 and RegWriteEn = 1; 8 cycles total.
- beq (0x04), zero = 1 then zero = 0 -> PCWrite = 1 and PCSrc = 1 in EXEC for the first; PCWrite = 0 for the second; no RegWriteEn or MemWriteEn in either.
- Opcode 0x3f, then op 0x00 with funct 0x07 -> illegal = 1 for exactly one DECODE cycle each; next state FETCH; RegWriteEn and MemWriteEn never asserted.
- sw (0x2b) with mem_ready held 0 and WAIT_LIMIT = 15 -> MemWriteEn high for 16 cycles, then state = 7 with fault = 1 and MemWriteEn = 0; fault stays set until rst low.
- rst driven low during lw MEM -> MemReadEn drops in the same cycle; after release, state = 0 and MemReadEn = 1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : Registered FETCH/DECODE/EXEC/MEM/WB controller for the multicycle
//            MIPS-subset datapath. Memory-wait timeout latches a sticky fault.
//            Optional bne/j support is enabled by defining EXT_BRANCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int ALUOP_W    = 3,
  parameter int WAIT_LIMIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opCode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               MemReadEn,
  output logic               MemWriteEn,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWriteEn,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               illegal,
  output logic               fault,
  output logic [2:0]         state
);

  localparam int c_CNT_W = $clog2(WAIT_LIMIT + 1);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2b;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
`ifdef EXT_BRANCH_EN
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_J     = 6'h02;
`endif

  localparam logic [5:0] c_FN_ADD = 6'h20;
  localparam logic [5:0] c_FN_SUB = 6'h22;
  localparam logic [5:0] c_FN_AND = 6'h24;
  localparam logic [5:0] c_FN_OR  = 6'h25;
  localparam logic [5:0] c_FN_SLT = 6'h2a;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [5:0]         r_op;
  logic [5:0]         r_funct;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_fault;
  logic               w_timeout;
  logic               w_legal;
  logic [2:0]         w_aluop_fn;

  assign state     = r_state;
  assign w_timeout = (r_cnt == c_CNT_W'(WAIT_LIMIT)) && !mem_ready;

  // Legality is judged on the live IR fields during DECODE.
  always_comb begin
    w_legal = 1'b0;
    case (opCode)
      c_OP_RTYPE: w_legal = (funct inside {c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_SLT});
      c_OP_ADDI, c_OP_LW, c_OP_SW, c_OP_BEQ: w_legal = 1'b1;
`ifdef EXT_BRANCH_EN
      c_OP_BNE, c_OP_J: w_legal = 1'b1;
`endif
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_aluop_fn = 3'd0;
    case (r_funct)
      c_FN_SUB: w_aluop_fn = 3'd1;
      c_FN_AND: w_aluop_fn = 3'd2;
      c_FN_OR:  w_aluop_fn = 3'd3;
      c_FN_SLT: w_aluop_fn = 3'd4;
      default:  w_aluop_fn = 3'd0;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemReadEn  = 1'b0;
    MemWriteEn = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWriteEn = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'd0;
    PCSrc      = 1'b0;
    ALUOp      = '0;
    illegal    = 1'b0;
    fault      = r_fault;

    case (r_state)
      S_FETCH: begin
        MemReadEn = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = 2'd1;
          w_next  = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end

      S_DECODE: begin
        ALUSrcB = 2'd3;
        if (!w_legal) begin
          illegal = 1'b1;
          w_next  = S_FETCH;
`ifdef EXT_BRANCH_EN
        end else if (opCode == c_OP_J) begin
          PCWrite = 1'b1;
          PCSrc   = 1'b1;
          w_next  = S_FETCH;
`endif
        end else begin
          w_next = S_EXEC;
        end
      end

      S_EXEC: begin
        ALUSrcA = 1'b1;
        w_next  = S_FETCH;
        case (r_op)
          c_OP_RTYPE: begin
            ALUOp[2:0] = w_aluop_fn;
            w_next     = S_WB;
          end
          c_OP_ADDI: begin
            ALUSrcB = 2'd2;
            w_next  = S_WB;
          end
          c_OP_LW, c_OP_SW: begin
            ALUSrcB = 2'd2;
            w_next  = S_MEM;
          end
          c_OP_BEQ: begin
            ALUOp[2:0] = 3'd1;
            PCSrc      = 1'b1;
            PCWrite    = zero;
          end
`ifdef EXT_BRANCH_EN
          c_OP_BNE: begin
            ALUOp[2:0] = 3'd1;
            PCSrc      = 1'b1;
            PCWrite    = ~zero;
          end
`endif
          default: w_next = S_FETCH;
        endcase
      end

      S_MEM: begin
        IorD = 1'b1;
        if (r_op == c_OP_LW) MemReadEn  = 1'b1;
        else                 MemWriteEn = 1'b1;
        if (mem_ready)      w_next = (r_op == c_OP_LW) ? S_WB : S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
      end

      S_WB: begin
        RegWriteEn = 1'b1;
        RegDst     = (r_op == c_OP_RTYPE);
        MemtoReg   = (r_op == c_OP_LW);
        w_next     = S_FETCH;
      end

      S_FAULT: w_next = S_FAULT;

      default: w_next = S_FETCH;
    endcase

    // Reset gates the outputs combinationally so strobes drop mid-cycle.
    if (!rst) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      IorD       = 1'b0;
      MemReadEn  = 1'b0;
      MemWriteEn = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWriteEn = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'd0;
      PCSrc      = 1'b0;
      ALUOp      = '0;
      illegal    = 1'b0;
      fault      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_fault <= 1'b0;
      r_op    <= '0;
      r_funct <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_FAULT) r_fault <= 1'b1;
      if (r_state == S_DECODE) begin
        r_op    <= opCode;
        r_funct <= funct;
      end
      if ((w_next != r_state) || mem_ready ||
          !((r_state == S_FETCH) || (r_state == S_MEM)))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Brief    : Scoreboard bench: per-cycle expected control vectors are queued
//            with the stimulus and popped against the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opCode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, IRWrite, IorD, MemReadEn, MemWriteEn, RegDst, MemtoReg;
  logic       RegWriteEn, ALUSrcA, PCSrc, illegal, fault;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  logic [19:0] exp_q[$];
  logic        rdy_q[$];

  multicycle_control_unit #(.ALUOP_W(3), .WAIT_LIMIT(15)) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
    .MemReadEn(MemReadEn), .MemWriteEn(MemWriteEn), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWriteEn(RegWriteEn), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp), .illegal(illegal),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input logic [2:0] st, input logic pcw, irw, iord,
                                     mrd, mwr, rdst, m2r, rwe, asa, input logic [1:0] asb,
                                     input logic pcs, input logic [2:0] aop, input logic ill, flt);
    return {st, pcw, irw, iord, mrd, mwr, rdst, m2r, rwe, asa, asb, pcs, aop, ill, flt};
  endfunction

  function automatic logic [19:0] obs();
    return {state, PCWrite, IRWrite, IorD, MemReadEn, MemWriteEn, RegDst, MemtoReg,
            RegWriteEn, ALUSrcA, ALUSrcB, PCSrc, ALUOp, illegal, fault};
  endfunction

  // Reference control vectors, one per state/instruction class.
  function automatic logic [19:0] e_fetch(input logic rdy);
    return rdy ? mk(3'd0, 1,1,0,1,0, 0,0,0, 0,2'd1,0,3'd0, 0,0)
               : mk(3'd0, 0,0,0,1,0, 0,0,0, 0,2'd0,0,3'd0, 0,0);
  endfunction
  function automatic logic [19:0] e_decode(input logic ill);
    return mk(3'd1, 0,0,0,0,0, 0,0,0, 0,2'd3,0,3'd0, ill,0);
  endfunction
  function automatic logic [19:0] e_exec_rr(input logic [2:0] aop);
    return mk(3'd2, 0,0,0,0,0, 0,0,0, 1,2'd0,0,aop, 0,0);
  endfunction
  function automatic logic [19:0] e_exec_imm();
    return mk(3'd2, 0,0,0,0,0, 0,0,0, 1,2'd2,0,3'd0, 0,0);
  endfunction
  function automatic logic [19:0] e_exec_beq(input logic z);
    return mk(3'd2, z,0,0,0,0, 0,0,0, 1,2'd0,1,3'd1, 0,0);
  endfunction
  function automatic logic [19:0] e_mem(input logic is_lw);
    return mk(3'd3, 0,0,1,is_lw,!is_lw, 0,0,0, 0,2'd0,0,3'd0, 0,0);
  endfunction
  function automatic logic [19:0] e_wb(input logic rdst, input logic m2r);
    return mk(3'd4, 0,0,0,0,0, rdst,m2r,1, 0,2'd0,0,3'd0, 0,0);
  endfunction
  function automatic logic [19:0] e_fault();
    return mk(3'd7, 0,0,0,0,0, 0,0,0, 0,2'd0,0,3'd0, 0,1);
  endfunction

  task automatic push(input logic [19:0] e, input logic r);
    exp_q.push_back(e);
    rdy_q.push_back(r);
  endtask

  task automatic test_reset();
    logic [19:0] got;
    rst = 1'b0;
    mem_ready = 1'b1;
    #2;
    got = obs();
    n_cmp++;
    if (got !== 20'h0) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", got, 20'h0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    got = obs();
    n_cmp++;
    if (got !== e_fetch(1'b0)) begin
      n_err++;
      $display("FAIL reset_release: got %h want %h", got, e_fetch(1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_rtype();
    logic [19:0] got, want;
    logic [5:0]  fn;
    logic [2:0]  aop;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin fn = 6'h20; aop = 3'd0; end
        1: begin fn = 6'h22; aop = 3'd1; end
        2: begin fn = 6'h24; aop = 3'd2; end
        3: begin fn = 6'h25; aop = 3'd3; end
        default: begin fn = 6'h2a; aop = 3'd4; end
      endcase
      opCode = 6'h00;
      funct  = fn;
      push(e_fetch(1'b1), 1'b1);
      push(e_decode(1'b0), 1'b1);
      push(e_exec_rr(aop), 1'b1);
      push(e_wb(1'b1, 1'b0), 1'b1);
      for (int i = 0; exp_q.size() > 0; i++) begin
        mem_ready = rdy_q.pop_front();
        #1;
        got  = obs();
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
          n_err++;
          $display("FAIL rtype_f%h cyc%0d: got %h want %h", fn, i, got, want);
        end
        @(negedge clk);
        if (i == 1) begin opCode = 6'h3f; funct = 6'h3f; end
      end
    end
  endtask

  task automatic test_addi();
    logic [19:0] got, want;
    opCode = 6'h08;
    funct  = 6'h11;
    push(e_fetch(1'b1), 1'b1);
    push(e_decode(1'b0), 1'b1);
    push(e_exec_imm(), 1'b1);
    push(e_wb(1'b0, 1'b0), 1'b1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      mem_ready = rdy_q.pop_front();
      #1;
      got  = obs();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL addi cyc%0d: got %h want %h", i, got, want);
      end
      @(negedge clk);
      if (i == 1) begin opCode = 6'h3f; funct = 6'h3f; end
    end
  endtask

  task automatic test_lw_wait();
    logic [19:0] got, want;
    opCode = 6'h23;
    funct  = 6'h00;
    push(e_fetch(1'b1), 1'b1);
    push(e_decode(1'b0), 1'b0);
    push(e_exec_imm(), 1'b0);
    for (int w = 0; w < 3; w++) push(e_mem(1'b1), 1'b0);
    push(e_mem(1'b1), 1'b1);
    push(e_wb(1'b0, 1'b1), 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      mem_ready = rdy_q.pop_front();
      #1;
      got  = obs();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL lw_wait cyc%0d: got %h want %h", i, got, want);
      end
      @(negedge clk);
      if (i == 1) begin opCode = 6'h3f; funct = 6'h3f; end
    end
  endtask

  task automatic test_beq();
    logic [19:0] got, want;
    for (int k = 0; k < 2; k++) begin
      opCode = 6'h04;
      funct  = 6'h00;
      zero   = (k == 0);
      push(e_fetch(1'b1), 1'b1);
      push(e_decode(1'b0), 1'b1);
      push(e_exec_beq(k == 0), 1'b1);
      for (int i = 0; exp_q.size() > 0; i++) begin
        mem_ready = rdy_q.pop_front();
        #1;
        got  = obs();
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
          n_err++;
          $display("FAIL beq_z%0d cyc%0d: got %h want %h", zero, i, got, want);
        end
        @(negedge clk);
        if (i == 1) begin opCode = 6'h3f; funct = 6'h3f; end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    logic [19:0] got, want;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin opCode = 6'h3f; funct = 6'h20; end
        1: begin opCode = 6'h00; funct = 6'h07; end
        default: begin opCode = 6'h02; funct = 6'h00; end
      endcase
      push(e_fetch(1'b1), 1'b1);
      push(e_decode(1'b1), 1'b1);
      push(e_fetch(1'b0), 1'b0);
      for (int i = 0; exp_q.size() > 0; i++) begin
        mem_ready = rdy_q.pop_front();
        #1;
        got  = obs();
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
          n_err++;
          $display("FAIL illegal_%0d cyc%0d: got %h want %h", k, i, got, want);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_sw_timeout();
    logic [19:0] got, want;
    opCode = 6'h2b;
    funct  = 6'h00;
    push(e_fetch(1'b1), 1'b1);
    push(e_decode(1'b0), 1'b0);
    push(e_exec_imm(), 1'b0);
    for (int w = 0; w < 16; w++) push(e_mem(1'b0), 1'b0);
    push(e_fault(), 1'b0);
    push(e_fault(), 1'b1);
    push(e_fault(), 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      mem_ready = rdy_q.pop_front();
      #1;
      got  = obs();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL sw_timeout cyc%0d: got %h want %h", i, got, want);
      end
      @(negedge clk);
      if (i == 1) begin opCode = 6'h3f; funct = 6'h3f; end
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] got, want;
    rst = 1'b0;
    #1;
    got = obs();
    n_cmp++;
    if (got !== 20'h0) begin
      n_err++;
      $display("FAIL reset_in_fault: got %h want %h", got, 20'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    opCode = 6'h23;
    funct  = 6'h00;
    push(e_fetch(1'b1), 1'b1);
    push(e_decode(1'b0), 1'b0);
    push(e_exec_imm(), 1'b0);
    push(e_mem(1'b1), 1'b0);
    push(e_mem(1'b1), 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      mem_ready = rdy_q.pop_front();
      #1;
      got  = obs();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL lw_pre_reset cyc%0d: got %h want %h", i, got, want);
      end
      if (exp_q.size() == 0) begin
        rst = 1'b0;
        #1;
        got = obs();
        n_cmp++;
        if (got !== 20'h0) begin
          n_err++;
          $display("FAIL reset_mid_mem: got %h want %h", got, 20'h0);
        end
      end
      @(negedge clk);
      if (i == 1) begin opCode = 6'h3f; funct = 6'h3f; end
    end
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    got = obs();
    n_cmp++;
    if (got !== e_fetch(1'b0)) begin
      n_err++;
      $display("FAIL after_reset: got %h want %h", got, e_fetch(1'b0));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_addi();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_sw_timeout();
    test_reset_mid();
    test_addi();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
